// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between an issuing agent and alu_issue_ctrl.
// master = request producer / response consumer; slave = alu_issue_ctrl.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [5:0]  req_funct;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_shamt;
    logic [15:0] req_imm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [2:0]  resp_flags;
    logic        resp_wb;
    logic        resp_wb_sel;

    modport master (
        output req_valid, req_op, req_funct, req_rs, req_rt, req_rd, req_shamt, req_imm, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags, resp_wb, resp_wb_sel
    );
    modport slave (
        input  req_valid, req_op, req_funct, req_rs, req_rt, req_rd, req_shamt, req_imm, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags, resp_wb, resp_wb_sel
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one MIPS-encoded operation at a time to an external ALU, waits a fixed
// latency, writes the result back into a 2-entry register file and returns a response.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [31:0]       load_data,
    output logic [31:0]       instruction,
    output logic [31:0]       reg_a,
    output logic [31:0]       reg_b,
    input  logic [31:0]       alu_result,
    input  logic [2:0]        alu_flags,
    output logic [31:0]       r0_q,
    output logic [31:0]       r1_q,
    output logic [CNT_W-1:0]  op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t      state, state_nxt;
    logic [3:0]  lat_cnt;
    logic [31:0] r0, r1;
    logic        wb_en, wb_sel;
    logic        req_wb_en, req_wb_sel;
    logic [31:0] req_word;

    // Destination decode: R-type writes rd, selected ALU-immediate opcodes write rt.
    always_comb begin
        req_wb_en  = 1'b0;
        req_wb_sel = 1'b0;
        if (bus.req_op == 6'h00) begin
            req_wb_en  = 1'b1;
            req_wb_sel = |bus.req_rd;
        end else begin
            case (bus.req_op)
                6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin
                    req_wb_en  = 1'b1;
                    req_wb_sel = |bus.req_rt;
                end
                default: req_wb_en = 1'b0;
            endcase
        end
        req_word = (bus.req_op == 6'h00)
                 ? {6'b0, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_shamt, bus.req_funct}
                 : {bus.req_op, bus.req_rs, bus.req_rt, bus.req_imm};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid)     state_nxt = EXEC;
            EXEC: if (lat_cnt == 4'd1)   state_nxt = WB;
            WB:                          state_nxt = RESP;
            RESP: if (bus.resp_ready)    state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction     <= '0;
            lat_cnt         <= '0;
            r0              <= '0;
            r1              <= '0;
            wb_en           <= 1'b0;
            wb_sel          <= 1'b0;
            bus.resp_result <= '0;
            bus.resp_flags  <= '0;
            bus.resp_wb     <= 1'b0;
            bus.resp_wb_sel <= 1'b0;
            op_count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A preload in the accepting cycle lands before EXEC, so the op sees it.
                    if (load_en) begin
                        if (load_sel) r1 <= load_data;
                        else          r0 <= load_data;
                    end
                    if (bus.req_valid) begin
                        instruction <= req_word;
                        lat_cnt     <= LAT_INIT;
                        wb_en       <= req_wb_en;
                        wb_sel      <= req_wb_sel;
                    end
                end
                EXEC: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        bus.resp_result <= alu_result;
                        bus.resp_flags  <= alu_flags;
                    end
                end
                WB: begin
                    if (wb_en) begin
                        if (wb_sel) r1 <= bus.resp_result;
                        else        r0 <= bus.resp_result;
                    end
                    bus.resp_wb     <= wb_en;
                    bus.resp_wb_sel <= wb_en & wb_sel;
                    op_count        <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign reg_a = r0;
    assign reg_b = r1;
    assign r0_q  = r0;
    assign r1_q  = r1;
endmodule
